logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand/result width, legal 1..64.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the transaction counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands this cycle.
REQ-007 The block SHALL have ports A, input, WIDTH bits, and B, input, WIDTH bits: operands.
REQ-008 The block SHALL have port op, input, 3 bits: operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is held.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port Y, output, WIDTH bits: registered result.
REQ-012 The block SHALL have ports zero, all_ones and parity, each output, 1 bit: registered flags of Y.
REQ-013 The block SHALL have port txn_count, output, CNT_W bits: count of completed output handshakes.

Function
REQ-014 op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT A, 111 PASS A; all codes are legal.
REQ-015 In-accept SHALL occur when in_valid && in_ready; out-handshake SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !rst, combinationally.
REQ-017 On in-accept, Y SHALL load f(op, A, B) on that clock edge and out_valid SHALL be 1 the next cycle: latency 1.
REQ-018 On in-accept, the flags SHALL load from the new result: zero = (result == 0), all_ones = (result == all 1s), parity = XOR-reduction of result.
REQ-019 While out_valid && !out_ready, Y, flags and out_valid SHALL hold stable regardless of A, B, op or in_valid.
REQ-020 An out-handshake without a same-cycle in-accept SHALL clear out_valid on the next edge; Y and the flags SHALL keep their last values.
REQ-021 A same-cycle out-handshake and in-accept SHALL load the new result with out_valid staying 1, giving full throughput of one result per cycle.
REQ-022 The state machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-023 Transitions SHALL be: EMPTY->FULL on in-accept; FULL->EMPTY on out-handshake without in-accept; FULL->FULL otherwise.
REQ-024 txn_count SHALL increment by 1 on each out-handshake and wrap from 2^CNT_W-1 to 0 without a flag.
REQ-025 With WIDTH=1, the flags SHALL still be defined as in REQ-018, so parity = Y and all_ones = Y.

Reset
REQ-026 While rst=1 at a clock edge, out_valid, Y, zero, parity and txn_count SHALL become 0 and all_ones SHALL become 0.
REQ-027 Reset asserted mid-transaction SHALL discard any held result with no out-handshake counted; in_ready SHALL be 0 throughout reset.
REQ-028 In the first cycle after rst deasserts, in_ready SHALL be 1.

Structure
REQ-029 Package logic_unit_pkg SHALL hold the op enum (the 3-bit typedef with the 8 named codes) and the default WIDTH/CNT_W constants.
REQ-030 Pure combinational function f SHALL live in sub-module logic_op_core (A, B, op -> result, WIDTH-parametrised); logic_unit_pipe SHALL instantiate it once and hold all registers.

Verification
REQ-031 Bench SHALL cover the truth table: WIDTH=8, A=8'hF0, B=8'hCC, each op, out_ready=1 -> Y = C0, FC, 3C, C3, 3F, 03, 0F, F0 respectively, one cycle after accept.
REQ-032 Bench SHALL cover flags: XNOR with A=B=8'h5A -> Y=FF, all_ones=1, zero=0, parity=0; XOR with A=B -> Y=00, zero=1.
REQ-033 Bench SHALL cover backpressure: accept AND 8'hFF,8'h81, hold out_ready=0 for 5 cycles while changing A/B -> Y stays 81, in_ready=0; then out_ready=1 -> one handshake, txn_count=1.
REQ-034 Bench SHALL cover streaming: in_valid=out_ready=1 for 10 back-to-back ops -> 10 results in order on consecutive cycles, in_ready constantly 1, txn_count=10.
REQ-035 Bench SHALL cover wrap: CNT_W=3, 9 handshakes -> txn_count reads 7 then 0 then 1.
REQ-036 Bench SHALL cover reset mid-op: FULL with out_ready=0, pulse rst for 1 cycle -> out_valid=0, Y=0, txn_count=0; next cycle in_ready=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types and default sizing for the logic unit pipeline.
package logic_unit_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_NOT_A = 3'b110,
        OP_PASS  = 3'b111
    } op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/logic_op_core.sv
// Pure combinational bitwise operator: result = f(op, A, B).
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    op_e op_sel;

    assign op_sel = op_e'(op);

    // Select the bitwise function; every 3-bit code maps to an operation.
    always_comb begin
        result = '0;
        case (op_sel)
            OP_AND:   result = A & B;
            OP_OR:    result = A | B;
            OP_XOR:   result = A ^ B;
            OP_XNOR:  result = ~(A ^ B);
            OP_NAND:  result = ~(A & B);
            OP_NOR:   result = ~(A | B);
            OP_NOT_A: result = ~A;
            OP_PASS:  result = A;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Single-stage registered logic unit with valid/ready handshakes,
// result flags and a wrapping count of completed output handshakes.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | no result held, out_valid = 0
// S_FULL  | result held in Y/flags, out_valid = 1
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             all_ones,
    output logic             parity,
    output logic [CNT_W-1:0] txn_count
);

    pipe_state_e      state;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             handshake;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A      (A),
        .B      (B),
        .op     (op),
        .result (result)
    );

    // The state register bit is the valid flag, so out_valid is a flop output.
    assign out_valid = (state == S_FULL);
    // A held result can be replaced in the same cycle it is consumed.
    assign in_ready  = (!out_valid || out_ready) && !rst;
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Occupancy FSM, result/flag registers and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            Y         <= '0;
            zero      <= 1'b0;
            all_ones  <= 1'b0;
            parity    <= 1'b0;
            txn_count <= '0;
        end else begin
            case (state)
                S_EMPTY: if (accept)                state <= S_FULL;
                S_FULL:  if (handshake && !accept)  state <= S_EMPTY;
                default:                            state <= S_EMPTY;
            endcase
            if (accept) begin
                Y        <= result;
                zero     <= (result == '0);
                all_ones <= &result;
                parity   <= ^result;
            end
            if (handshake) begin
                txn_count <= txn_count + CNT_W'(1);
            end
        end
    end

endmodule
